enc_input_key: RTL

ENC_INPUT_KEY -- requirements
Module: enc_input_key

---
 rtl/enc_input_key_pkg.sv | 23 ++
 rtl/enc_input_key.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/enc_input_key_pkg.sv
// -----------------------------------------------------------------------------
// enc_input_key_pkg
// Shared controller package for the serial key link. Holds the key length and
// value and the frame-state encoding, so the encoder (enc_input_key) and the
// decoder (DecInputKey) agree on both.
// -----------------------------------------------------------------------------
package enc_input_key_pkg;

    localparam int                 KEY_LEN   = 4;
    localparam logic [KEY_LEN-1:0] KEY_VALUE = 4'b1010;

    // The bit counter only has to reach KEY_LEN-1 inside a frame; three bits
    // leave headroom so it never wraps.
    localparam int                 BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_KEY  = 2'd1,
        SEND_MODE = 2'd2,
        GAP       = 2'd3
    } key_state_t;

endpackage : enc_input_key_pkg

// File: rtl/enc_input_key.sv
// -----------------------------------------------------------------------------
// enc_input_key
// Serialises one key frame toward the key decoder: KEY_LEN key bits MSB first
// (optionally corrupted by BAD_MASK), then one mode bit, then GAP_CYCLES idle
// cycles, then a one-cycle done pulse. All outputs are registered.
//
// Parameters
//   GAP_CYCLES  idle cycles after each frame before done (0 skips the gap)
//   BAD_MASK    XOR mask applied to the key when inject_bad is set
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous active-high reset
//   start       request one frame (accepted only in IDLE, never queued)
//   mode_in     mode bit carried at the end of the frame (latched on accept)
//   inject_bad  send KEY_VALUE ^ BAD_MASK instead of KEY_VALUE (latched)
//   inputKey    serial key/mode bit, 0 whenever validCmd is 0
//   validCmd    high while inputKey carries frame bits
//   busy        high from acceptance until the done cycle
//   done        one-cycle pulse when the frame (including gap) is finished
// -----------------------------------------------------------------------------
module enc_input_key
    import enc_input_key_pkg::*;
#(
    parameter int                 GAP_CYCLES = 2,
    parameter logic [KEY_LEN-1:0] BAD_MASK   = 4'b0011
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mode_in,
    input  logic inject_bad,
    output logic inputKey,
    output logic validCmd,
    output logic busy,
    output logic done
);

    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [BIT_CNT_W-1:0] KEY_LAST = BIT_CNT_W'(KEY_LEN - 1);

    key_state_t             r_state;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [KEY_LEN-1:0]     r_key_sh;
    logic                   r_mode;
    logic                   r_input_key;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;

    key_state_t             w_state_nxt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
    logic [GAP_W-1:0]       w_gap_cnt_nxt;
    logic [KEY_LEN-1:0]     w_key_sh_nxt;
    logic                   w_mode_nxt;
    logic                   w_input_key_nxt;
    logic                   w_valid_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic [KEY_LEN-1:0]     w_key_sel;

    assign w_key_sel = inject_bad ? (KEY_VALUE ^ BAD_MASK) : KEY_VALUE;

    // Next-state and next-output logic. The key MSB goes out on the accepting
    // edge itself, so the shift register holds only the remaining bits and the
    // bit counter (cleared on entry) counts those remaining bits.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; otherwise synthesis infers a latch.
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_key_sh_nxt    = r_key_sh;
        w_mode_nxt      = r_mode;
        w_input_key_nxt = 1'b0;
        w_valid_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = SEND_KEY;
                    w_bit_cnt_nxt   = '0;
                    w_key_sh_nxt    = {w_key_sel[KEY_LEN-2:0], 1'b0};
                    w_mode_nxt      = mode_in;
                    w_input_key_nxt = w_key_sel[KEY_LEN-1];
                    w_valid_nxt     = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end

            SEND_KEY: begin
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
                if (r_bit_cnt == KEY_LAST) begin
                    // All key bits are out; the mode bit follows.
                    w_input_key_nxt = r_mode;
                    w_state_nxt     = SEND_MODE;
                end else begin
                    w_input_key_nxt = r_key_sh[KEY_LEN-1];
                    w_key_sh_nxt    = {r_key_sh[KEY_LEN-2:0], 1'b0};
                    w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                end
            end

            SEND_MODE: begin
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt   = GAP;
                    w_gap_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = IDLE;
                    w_gap_cnt_nxt = '0;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_key_sh    <= '0;
            r_mode      <= 1'b0;
            r_input_key <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_key_sh    <= w_key_sh_nxt;
            r_mode      <= w_mode_nxt;
            r_input_key <= w_input_key_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign inputKey = r_input_key;
    assign validCmd = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : enc_input_key
